dp_rr_scheduler: RTL and testbench

- Shares one fixed-latency 8-bit datapath unit between NUM_REQ requesters.
- The datapath is the unit driven by enable/modifier strobes and an operand byte, i.e. the logic under synthesis test.
- Round-robin arbitration, registered issue, tag pipeline matching returning results to their requester, per-requester response FIFO with credit flow control.
- Sits between the board-level operand sources (switch bytes/stimulus) and the shared datapath; results go to LED-side consumers.

---
 rtl/dp_sched_pkg.sv | 29 ++
 rtl/dp_resp_fifo.sv | 62 ++++++
 rtl/dp_rr_scheduler.sv | 197 +++++++++++++++++++
 tb/tb_dp_rr_scheduler.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dp_sched_pkg.sv
// Shared types and width helpers for the round-robin datapath scheduler.
package dp_sched_pkg;

  // Largest requester count the tag id field can address.
  localparam int unsigned MAX_NUM_REQ = 16;
  localparam int unsigned ID_W        = $clog2(MAX_NUM_REQ);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  typedef struct packed {
    logic            valid;
    logic [ID_W-1:0] id;
  } tag_t;

  // Width of a counter that must hold 0..n inclusive.
  function automatic int unsigned cnt_w(input int unsigned n);
    return $clog2(n + 1);
  endfunction

  // Width of an index over n items, never below one bit.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/dp_resp_fifo.sv
// Per-requester response FIFO: registered storage, head visible the cycle
// after a push; push and pop may coincide, including when full.
module dp_resp_fifo
  import dp_sched_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              push_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              pop_i,
  output logic              valid_o,
  output logic [DATA_W-1:0] data_o
);

  localparam int unsigned AW = idx_w(DEPTH);
  localparam int unsigned CW = cnt_w(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [CW-1:0]     r_count;
  logic              w_full;
  logic              w_do_pop;
  logic              w_do_push;

  function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign w_full    = (r_count == CW'(DEPTH));
  assign w_do_pop  = pop_i && (r_count != '0);
  // At full with a pop, the write lands on the slot being vacated.
  assign w_do_push = push_i && (!w_full || w_do_pop);

  assign valid_o = (r_count != '0);
  assign data_o  = r_mem[r_rd_ptr];

  // Storage, pointers and occupancy.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int unsigned k = 0; k < DEPTH; k++) r_mem[k] <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr] <= data_i;
        r_wr_ptr        <= next_ptr(r_wr_ptr);
      end
      if (w_do_pop) r_rd_ptr <= next_ptr(r_rd_ptr);
      if (w_do_push && !w_do_pop)      r_count <= r_count + CW'(1);
      else if (!w_do_push && w_do_pop) r_count <= r_count - CW'(1);
    end
  end

  a_no_overflow: assert property (@(posedge clk_i) disable iff (rst_i)
    !(push_i && w_full && !w_do_pop));

endmodule

// File: rtl/dp_rr_scheduler.sv
// Round-robin scheduler sharing one fixed-latency datapath among NUM_REQ
// requesters, with tag-matched returns into credit-limited response FIFOs.
// Optional build macro SYN_OPT_DP_PERF_EN adds grant/stall perf counters.
module dp_rr_scheduler
  import dp_sched_pkg::*;
#(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned NUM_REQ    = 2,
  parameter int unsigned DP_LATENCY = 3,
  parameter int unsigned RESP_DEPTH = 2
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      flush_i,
  input  logic [NUM_REQ-1:0]        req_valid_i,
  output logic [NUM_REQ-1:0]        req_ready_o,
  input  logic [NUM_REQ*DATA_W-1:0] req_data_i,
  input  logic [NUM_REQ-1:0]        req_modif_i,
  output logic                      dp_enb_o,
  output logic                      dp_modif_o,
  output logic [DATA_W-1:0]         dp_data_o,
  input  logic [DATA_W-1:0]         dp_data_i,
  output logic [NUM_REQ-1:0]        resp_valid_o,
  output logic [NUM_REQ*DATA_W-1:0] resp_data_o,
  input  logic [NUM_REQ-1:0]        resp_ready_i,
  output logic                      busy_o
`ifdef SYN_OPT_DP_PERF_EN
  ,
  output logic [NUM_REQ*32-1:0]     perf_grant_cnt_o,
  output logic [31:0]               perf_stall_cnt_o
`endif
);

  localparam int unsigned PW = idx_w(NUM_REQ);
  localparam int unsigned CW = cnt_w(RESP_DEPTH);

  state_t        r_state;
  logic [PW-1:0] r_ptr;
  logic [CW-1:0] r_credit [NUM_REQ];
  logic [PW-1:0] r_issue_id;
  tag_t          r_tag [DP_LATENCY];

  logic [NUM_REQ-1:0] w_elig;
  logic [NUM_REQ-1:0] w_grant;
  logic [NUM_REQ-1:0] w_push;
  logic [NUM_REQ-1:0] w_pop;
  logic               w_grant_any;
  logic [PW-1:0]      w_grant_id;
  logic [PW-1:0]      w_arb_idx;
  logic               w_inflight;
  tag_t               w_ret;

  // Eligibility: valid, credit available, not draining.
  always_comb begin
    w_elig = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++)
      w_elig[i] = req_valid_i[i] && (r_credit[i] < CW'(RESP_DEPTH)) && (r_state != ST_DRAIN);
  end

  // First eligible requester searching upward from the pointer, wrapping.
  always_comb begin
    w_grant     = '0;
    w_grant_any = 1'b0;
    w_grant_id  = '0;
    w_arb_idx   = '0;
    for (int unsigned off = 0; off < NUM_REQ; off++) begin
      w_arb_idx = PW'((32'(r_ptr) + off) % NUM_REQ);
      if (!w_grant_any && w_elig[w_arb_idx]) begin
        w_grant_any          = 1'b1;
        w_grant_id           = w_arb_idx;
        w_grant[w_arb_idx]   = 1'b1;
      end
    end
  end

  assign req_ready_o = w_grant;
  assign w_pop       = resp_valid_o & resp_ready_i;
  assign w_ret       = r_tag[DP_LATENCY-1];

  // Route the returning result to the FIFO named by the last tag stage.
  always_comb begin
    w_push = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++)
      w_push[i] = w_ret.valid && (w_ret.id == ID_W'(i));
  end

  // Work in flight: issue register or any tag stage occupied.
  always_comb begin
    w_inflight = dp_enb_o;
    for (int unsigned k = 0; k < DP_LATENCY; k++)
      w_inflight = w_inflight | r_tag[k].valid;
  end

  assign busy_o = (r_state != ST_IDLE) || w_inflight;

  // Round-robin pointer advances past the winner.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_ptr <= '0;
    else if (w_grant_any)
      r_ptr <= (w_grant_id == PW'(NUM_REQ - 1)) ? '0 : w_grant_id + PW'(1);
  end

  // Credits count in-flight plus buffered entries per requester.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < NUM_REQ; i++) r_credit[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (w_grant[i] && !w_pop[i])      r_credit[i] <= r_credit[i] + CW'(1);
        else if (!w_grant[i] && w_pop[i]) r_credit[i] <= r_credit[i] - CW'(1);
      end
    end
  end

  // Registered issue to the datapath; operand and modifier hold when idle.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      dp_enb_o   <= 1'b0;
      dp_modif_o <= 1'b0;
      dp_data_o  <= '0;
      r_issue_id <= '0;
    end else begin
      dp_enb_o <= w_grant_any;
      if (w_grant_any) begin
        dp_data_o  <= req_data_i[w_grant_id*DATA_W +: DATA_W];
        dp_modif_o <= req_modif_i[w_grant_id];
        r_issue_id <= w_grant_id;
      end
    end
  end

  // Tag pipeline fed from the issue register; last stage meets dp_data_i.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int unsigned k = 0; k < DP_LATENCY; k++) r_tag[k] <= '0;
    end else begin
      r_tag[0] <= '{valid: dp_enb_o, id: ID_W'(r_issue_id)};
      for (int unsigned k = 1; k < DP_LATENCY; k++) r_tag[k] <= r_tag[k-1];
    end
  end

  // Control FSM: flush stops grants and waits for the pipeline to empty.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_state <= ST_IDLE;
    else begin
      case (r_state)
        ST_IDLE:  if ((|req_valid_i) && !flush_i) r_state <= ST_RUN;
        ST_RUN:   if (flush_i) r_state <= ST_DRAIN;
                  else if (!(|req_valid_i) && !w_inflight) r_state <= ST_IDLE;
        ST_DRAIN: if (!w_inflight) r_state <= ST_IDLE;
        default:  r_state <= ST_IDLE;
      endcase
    end
  end

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_fifo
    dp_resp_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (RESP_DEPTH)
    ) u_fifo (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .push_i  (w_push[g]),
      .data_i  (dp_data_i),
      .pop_i   (w_pop[g]),
      .valid_o (resp_valid_o[g]),
      .data_o  (resp_data_o[g*DATA_W +: DATA_W])
    );
  end

`ifdef SYN_OPT_DP_PERF_EN
  logic [31:0] r_grant_cnt [NUM_REQ];
  logic [31:0] r_stall_cnt;

  // Saturating grant and stall counters, cleared only by reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < NUM_REQ; i++) r_grant_cnt[i] <= '0;
      r_stall_cnt <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_REQ; i++)
        if (w_grant[i] && (r_grant_cnt[i] != '1)) r_grant_cnt[i] <= r_grant_cnt[i] + 32'd1;
      if ((|req_valid_i) && !w_grant_any && (r_stall_cnt != '1))
        r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  // Flatten grant counters onto the output bus.
  always_comb begin
    perf_grant_cnt_o = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) perf_grant_cnt_o[i*32 +: 32] = r_grant_cnt[i];
  end

  assign perf_stall_cnt_o = r_stall_cnt;
`endif

endmodule

// File: tb/tb_dp_rr_scheduler.sv
// Randomized bench for dp_rr_scheduler against a transaction-level model:
// every granted operation becomes an expected response with a due cycle.
module tb_dp_rr_scheduler;

  localparam int DW    = 8;
  localparam int NR    = 2;
  localparam int LAT   = 3;
  localparam int DEPTH = 2;

  logic               clk = 1'b0;
  logic               rst;
  logic               flush;
  logic [NR-1:0]      req_valid;
  logic [NR-1:0]      req_ready;
  logic [NR*DW-1:0]   req_data;
  logic [NR-1:0]      req_modif;
  logic               dp_enb;
  logic               dp_modif;
  logic [DW-1:0]      dp_data_o;
  logic [DW-1:0]      dp_data_i;
  logic [NR-1:0]      resp_valid;
  logic [NR*DW-1:0]   resp_data;
  logic [NR-1:0]      resp_ready;
  logic               busy;

  always #5 clk = ~clk;

  dp_rr_scheduler #(
    .DATA_W     (DW),
    .NUM_REQ    (NR),
    .DP_LATENCY (LAT),
    .RESP_DEPTH (DEPTH)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .flush_i      (flush),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready),
    .req_data_i   (req_data),
    .req_modif_i  (req_modif),
    .dp_enb_o     (dp_enb),
    .dp_modif_o   (dp_modif),
    .dp_data_o    (dp_data_o),
    .dp_data_i    (dp_data_i),
    .resp_valid_o (resp_valid),
    .resp_data_o  (resp_data),
    .resp_ready_i (resp_ready),
    .busy_o       (busy)
  );

  function automatic logic [DW-1:0] dp_fn(input logic [DW-1:0] d, input logic m);
    return m ? ~d : d + 8'h5A;
  endfunction

  // Behavioural datapath: fixed latency LAT from the issue cycle.
  logic [DW-1:0] dp_pipe [LAT];
  always @(posedge clk) begin
    dp_pipe[0] <= dp_fn(dp_data_o, dp_modif);
    for (int k = 1; k < LAT; k++) dp_pipe[k] <= dp_pipe[k-1];
  end
  assign dp_data_i = dp_pipe[LAT-1];

  // ---------------- reference model ----------------
  typedef struct {
    int          id;
    logic [7:0]  val;
    int          g;     // grant cycle
  } ent_t;

  ent_t        mq[$];
  int          cyc;
  int          m_ptr;
  int          m_st;    // 0 idle, 1 run, 2 drain
  logic        m_enb;
  logic [7:0]  m_data;
  logic        m_modif;

  int n_checks = 0;
  int n_errors = 0;
  int dut_grants [NR];
  int dut_pops;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int head_idx(input int id);
    for (int k = 0; k < mq.size(); k++) if (mq[k].id == id) return k;
    return -1;
  endfunction

  function automatic int occupancy(input int id);
    int n = 0;
    for (int k = 0; k < mq.size(); k++) if (mq[k].id == id) n++;
    return n;
  endfunction

  // An operation occupies the issue register / tag stages from g+1 to g+LAT+1.
  function automatic bit any_inflight();
    for (int k = 0; k < mq.size(); k++)
      if (mq[k].g + 1 <= cyc && cyc <= mq[k].g + LAT + 1) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_reset();
    mq.delete();
    m_ptr = 0; m_st = 0; m_enb = 1'b0; m_data = '0; m_modif = 1'b0;
  endtask

  // Compare one cycle's outputs (sampled mid-cycle) and advance the model.
  task automatic model_cycle();
    logic [NR-1:0] exp_rdy;
    logic [NR-1:0] exp_v;
    bit            gany;
    int            gid;
    int            h;
    bit            infl;
    bit            anyv;
    exp_rdy = '0; exp_v = '0; gany = 0; gid = 0;
    for (int off = 0; off < NR; off++) begin
      int r;
      r = (m_ptr + off) % NR;
      if (!gany && req_valid[r] && occupancy(r) < DEPTH && m_st != 2) begin
        gany = 1; gid = r; exp_rdy[r] = 1'b1;
      end
    end
    check_eq("req_ready", 32'(req_ready), 32'(exp_rdy));
    check_eq("dp_enb", 32'(dp_enb), 32'(m_enb));
    check_eq("dp_data", 32'(dp_data_o), 32'(m_data));
    check_eq("dp_modif", 32'(dp_modif), 32'(m_modif));
    for (int i = 0; i < NR; i++) begin
      h = head_idx(i);
      exp_v[i] = (h >= 0) && (mq[h].g + LAT + 2 <= cyc);
      check_eq($sformatf("resp_valid%0d", i), 32'(resp_valid[i]), 32'(exp_v[i]));
      if (exp_v[i]) check_eq($sformatf("resp_data%0d", i), 32'(resp_data[i*DW +: DW]), 32'(mq[h].val));
    end
    infl = any_inflight();
    anyv = |req_valid;
    check_eq("busy", 32'(busy), 32'((m_st != 0) || infl));
    for (int i = 0; i < NR; i++) begin
      if (req_ready[i]) dut_grants[i]++;
      if (resp_valid[i] && resp_ready[i]) dut_pops++;
      if (exp_v[i] && resp_ready[i]) mq.delete(head_idx(i));
    end
    m_enb = gany;
    if (gany) begin
      m_data  = req_data[gid*DW +: DW];
      m_modif = req_modif[gid];
      mq.push_back('{id: gid, val: dp_fn(req_data[gid*DW +: DW], req_modif[gid]), g: cyc});
      m_ptr = (gid + 1) % NR;
    end
    case (m_st)
      0: if (anyv && !flush) m_st = 1;
      1: if (flush) m_st = 2; else if (!anyv && !infl) m_st = 0;
      default: if (!infl) m_st = 0;
    endcase
    cyc++;
  endtask

  // Inputs are applied just after a rising edge; checks run on the falling edge.
  task automatic run_cycle();
    @(negedge clk);
    model_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [NR-1:0] v, input logic [NR-1:0] rdy, input logic fl);
    req_valid  = v;
    resp_ready = rdy;
    flush      = fl;
    for (int i = 0; i < NR; i++) begin
      req_data[i*DW +: DW] = 8'($urandom);
      req_modif[i]         = 1'($urandom);
    end
  endtask

  task automatic check_all_zero(input string pfx);
    check_eq({pfx, "_dp_enb"}, 32'(dp_enb), 32'd0);
    check_eq({pfx, "_dp_data"}, 32'(dp_data_o), 32'd0);
    check_eq({pfx, "_dp_modif"}, 32'(dp_modif), 32'd0);
    check_eq({pfx, "_resp_valid"}, 32'(resp_valid), 32'd0);
    check_eq({pfx, "_resp_data"}, 32'(resp_data), 32'd0);
    check_eq({pfx, "_req_ready"}, 32'(req_ready), 32'd0);
    check_eq({pfx, "_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int g1_before;
    int pops_before;
    cyc = 0;
    dut_pops = 0;
    for (int i = 0; i < NR; i++) dut_grants[i] = 0;
    model_reset();
    rst = 1'b1;
    drive('0, '1, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst = 1'b0;

    // Single request from requester 0.
    drive(2'b01, 2'b11, 1'b0);
    req_data[7:0] = 8'h10;
    req_modif[0]  = 1'b1;
    run_cycle();
    check_eq("single_dp_enb", 32'(dp_enb), 32'd1);
    check_eq("single_dp_data", 32'(dp_data_o), 32'h10);
    check_eq("single_dp_modif", 32'(dp_modif), 32'd1);
    drive('0, 2'b11, 1'b0);
    for (int k = 0; k < LAT + 1; k++) run_cycle();
    check_eq("single_resp_valid", 32'(resp_valid), 32'b01);
    check_eq("single_resp_data", 32'(resp_data[7:0]), 32'hEF);
    repeat (6) run_cycle();

    // Fairness with both requesters saturating.
    for (int i = 0; i < NR; i++) dut_grants[i] = 0;
    for (int k = 0; k < 100; k++) begin drive(2'b11, 2'b11, 1'b0); run_cycle(); end
    check_eq("fair_diff_le1",
             32'((dut_grants[0] - dut_grants[1] <= 1) && (dut_grants[1] - dut_grants[0] <= 1)), 32'd1);
    drive('0, 2'b11, 1'b0);
    repeat (10) run_cycle();

    // Backpressure on requester 1.
    for (int i = 0; i < NR; i++) dut_grants[i] = 0;
    for (int k = 0; k < 30; k++) begin drive(2'b11, 2'b01, 1'b0); run_cycle(); end
    check_eq("bp_grants1", 32'(dut_grants[1]), DEPTH);
    check_eq("bp_req0_served", 32'(dut_grants[0] >= 10), 32'd1);
    g1_before = dut_grants[1];
    for (int k = 0; k < 20; k++) begin drive(2'b11, 2'b11, 1'b0); run_cycle(); end
    check_eq("bp_resume", 32'(dut_grants[1] > g1_before), 32'd1);
    drive('0, 2'b11, 1'b0);
    repeat (10) run_cycle();

    // Flush with three operations in flight.
    pops_before = dut_pops;
    for (int k = 0; k < 3; k++) begin drive(2'b11, 2'b11, 1'b0); run_cycle(); end
    drive('0, 2'b11, 1'b1);
    run_cycle();
    for (int k = 0; k < 10; k++) begin drive('0, 2'b11, 1'b0); run_cycle(); end
    check_eq("flush_pops", 32'(dut_pops - pops_before), 32'd3);
    check_eq("flush_busy", 32'(busy), 32'd0);

    // Reset with work in flight.
    for (int k = 0; k < 3; k++) begin drive(2'b11, 2'b11, 1'b0); run_cycle(); end
    #2;
    drive('0, 2'b11, 1'b0);
    rst = 1'b1;
    #1;
    check_all_zero("midrst");
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    pops_before = dut_pops;
    for (int k = 0; k < 15; k++) begin drive('0, 2'b11, 1'b0); run_cycle(); end
    check_eq("midrst_no_resp", 32'(dut_pops - pops_before), 32'd0);

    // Fill FIFO0, then pop while returns keep arriving.
    for (int k = 0; k < 8; k++) begin drive(2'b01, 2'b00, 1'b0); run_cycle(); end
    for (int k = 0; k < 12; k++) begin drive(2'b01, 2'b01, 1'b0); run_cycle(); end
    drive('0, 2'b11, 1'b0);
    repeat (8) run_cycle();

    // Random traffic with occasional flushes.
    for (int k = 0; k < 600; k++) begin
      drive(2'($urandom), {($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < 7)},
            ($urandom_range(0, 24) == 0));
      run_cycle();
    end
    drive('0, 2'b11, 1'b0);
    repeat (15) run_cycle();
    check_eq("final_busy", 32'(busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
